// File: rtl/sdp_ram_be.sv
// sdp_ram_be: simple-dual-port RAM with byte enables, selectable read latency, read-during-write policy and post-reset clear
//   clk, rstn      : clock, synchronous active-low reset
//   i_wen/i_wbe    : write request and per-lane enables
//   i_waddr/i_wdata: write address and data
//   i_ren/i_raddr  : read request and address
//   o_rdata        : read data, holds between reads
//   o_rvalid       : one-cycle pulse when o_rdata is updated by a read
//   o_init_busy    : clear engine running, ports ignored
module sdp_ram_be #(
  parameter int DLEN       = 32,
  parameter int ALEN       = 4,
  parameter int BLEN       = 8,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_wen,
  input  logic [DLEN/BLEN-1:0] i_wbe,
  input  logic [ALEN-1:0]      i_waddr,
  input  logic [DLEN-1:0]      i_wdata,
  input  logic                 i_ren,
  input  logic [ALEN-1:0]      i_raddr,
  output logic [DLEN-1:0]      o_rdata,
  output logic                 o_rvalid,
  output logic                 o_init_busy
);
  localparam int NB = DLEN / BLEN;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [ALEN-1:0] cnt;
  logic [DLEN-1:0] ram [0:(1<<ALEN)-1];
  logic wr, rd;
  logic [DLEN-1:0] old_word, merged, rd_word;
  always_comb begin
    wr = rstn && state == RUN && i_wen;
    rd = rstn && state == RUN && i_ren;
    old_word = ram[i_raddr];
    merged = old_word;
    for (int k = 0; k < NB; k++)
      merged[k*BLEN +: BLEN] = i_wbe[k] ? i_wdata[k*BLEN +: BLEN] : old_word[k*BLEN +: BLEN];
    rd_word = (RDW_MODE != 0 && wr && i_waddr == i_raddr) ? merged : old_word;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= CLR_ON_RST != 0 ? CLEAR : RUN;
      cnt <= '0;
      o_init_busy <= CLR_ON_RST != 0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        state <= RUN;
        o_init_busy <= 1'b0;
      end
    end
  always_ff @(posedge clk)
    if (rstn && state == CLEAR)
      ram[cnt] <= '0;
    else if (wr)
      for (int k = 0; k < NB; k++)
        if (i_wbe[k]) ram[i_waddr][k*BLEN +: BLEN] <= i_wdata[k*BLEN +: BLEN];
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DLEN-1:0] p_data;
      logic p_valid;
      always_ff @(posedge clk)
        if (!rstn) begin
          p_data <= '0;
          p_valid <= 1'b0;
          o_rdata <= '0;
          o_rvalid <= 1'b0;
        end else begin
          p_valid <= rd;
          if (rd) p_data <= rd_word;
          o_rvalid <= p_valid;
          if (p_valid) o_rdata <= p_data;
        end
    end else begin : g_lat1
      always_ff @(posedge clk)
        if (!rstn) begin
          o_rdata <= '0;
          o_rvalid <= 1'b0;
        end else begin
          o_rvalid <= rd;
          if (rd) o_rdata <= rd_word;
        end
    end
  endgenerate
endmodule

// File: doc/sdp_ram_be.md
Name: sdp_ram_be

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, single clock.
- Successor to the team's single-port buffer RAM; adds per-byte write enables, explicit read enable with valid flag, selectable read latency and read-during-write policy, and a post-reset clear engine.
- Storage element for FIFOs and packet buffers.

Parameters:
- DLEN, 32, data width in bits; must be a multiple of BLEN.
- ALEN, 4, address width; depth = 2**ALEN words.
- BLEN, 8, byte-lane width; NB = DLEN/BLEN lanes.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (byte-merged) data.
- CLR_ON_RST, 1, 1 = zero all words after reset via clear engine; 0 = no clear.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- i_wen  input  1  write request.
- i_wbe  input  NB  per-lane write enable; lane k covers bits [k*BLEN +: BLEN].
- i_waddr  input  ALEN  write address.
- i_wdata  input  DLEN  write data.
- i_ren  input  1  read request.
- i_raddr  input  ALEN  read address.
- o_rdata  output  DLEN  read data; holds last value between reads.
- o_rvalid  output  1  one-cycle pulse marking o_rdata updated by a read.
- o_init_busy  output  1  high while the clear engine runs; ports ignored.

Behaviour:
- Reset values (rstn low at edge): o_rdata=0, o_rvalid=0, the RD_LAT=2 pipeline stage data and valid=0, clear counter=0, o_init_busy=CLR_ON_RST. Memory contents are not reset directly.
- Clear FSM, CLR_ON_RST=1, states CLEAR and RUN:
  - Reset forces CLEAR with counter 0.
  - In CLEAR, each cycle with rstn high writes all-zero to ram[counter] and increments the counter.
  - After writing address 2**ALEN-1, go to RUN. o_init_busy drops in the cycle after that edge.
  - Clear takes exactly 2**ALEN cycles after reset release.
  - Reset asserted mid-clear restarts from address 0.
  - CLR_ON_RST=0: FSM fixed in RUN, o_init_busy=0, memory contents undefined until written.
- While o_init_busy=1: i_wen and i_ren are ignored, no write occurs, o_rvalid stays 0.
- Write, in RUN: at an edge with i_wen=1, lane k of ram[i_waddr] takes i_wdata lane k iff i_wbe[k]=1. Other lanes are unchanged. i_wen=1 with i_wbe=0 changes nothing.
- Read, RD_LAT=1:
  - i_ren=1 sampled at edge N loads o_rdata at edge N and asserts o_rvalid for the following cycle.
  - i_ren=0: o_rdata holds and o_rvalid=0.
- Read, RD_LAT=2: the array read is registered at edge N, then o_rdata and o_rvalid update at edge N+1. Fully pipelined, so back-to-back reads give back-to-back valids.
- Read-during-write at the same address, same edge:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word, i_wdata in enabled lanes and the old word elsewhere.
  - Different addresses: no interaction.
- Address wrap: none. Any ALEN-bit address is valid, so no out-of-range case exists.
- Reset during an in-flight RD_LAT=2 read drops that read; no o_rvalid is produced.

Test Plan (DLEN=32, ALEN=4, BLEN=8):
- Clear: release reset with CLR_ON_RST=1 -> o_init_busy=1 for exactly 16 cycles. A write to addr 3 issued during busy is discarded. Then read all addresses -> each returns 0x00000000 with o_rvalid.
- Byte enables: write 0xAABBCCDD to addr 5 with wbe=0xF, then 0x11223344 with wbe=0x5 -> read addr 5 returns 0xAA22CC44. wen=1 with wbe=0 leaves it unchanged.
- Latency: RD_LAT=1 and RD_LAT=2 builds. Reads of addrs 0..3 on consecutive cycles after writing 0x10..0x13 -> o_rvalid pulses 1 or 2 cycles later respectively, data 0x10..0x13 in order, no gaps.
- RDW: addr 7 holds 0x01020304. Same-edge write 0xFFFFFFFF with wbe=0x3 plus read of addr 7 -> RDW_MODE=0 returns 0x01020304; RDW_MODE=1 returns 0x0102FFFF. A following read returns 0x0102FFFF in both modes.
- Hold: after a read returning 0x12345678, keep i_ren=0 for 5 cycles -> o_rdata stays 0x12345678, o_rvalid=0.
- Reset mid-operation: assert rstn low at clear count 9, release -> busy lasts a full 16 cycles again. Reset during a RD_LAT=2 read -> o_rdata=0, no o_rvalid pulse.
